// File: rtl/decoded_msg_uart_tx.sv
// Streams the decoded-message RAM out as 8N1 UART, LSB first, with optional CR LF trailer.
// Fetch is REQ/WAIT/LATCH per byte so a RAM with up to 2 cycles of read latency is covered.
module decoded_msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 32,
  parameter int ADDR_W       = 5,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rden,
  input  logic [7:0]        ram_q,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W     = ADDR_W + 2;
  localparam int NUM_BYTES = MSG_LEN + (APPEND_CRLF ? 2 : 0);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] MSG_END   = IDX_W'(MSG_LEN);
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  // Every registered output lives here, so outputs are never decoded from state.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [2:0]        bit_cnt;
    logic [CNT_W-1:0]  baud;
    logic [7:0]        shreg;
    logic [ADDR_W-1:0] addr;
    logic              rden;
    logic              tx;
    logic              busy;
    logic              done;
  } regs_t;

  localparam regs_t REGS_RST = '{
    idx: '0, bit_cnt: '0, baud: '0, shreg: '0, addr: '0,
    rden: 1'b0, tx: 1'b1, busy: 1'b0, done: 1'b0
  };

  state_t           state, state_nxt;
  regs_t            r, r_nxt;
  logic             baud_end;
  logic             in_crlf;
  logic [7:0]       crlf_byte;
  logic [IDX_W-1:0] idx_plus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      r     <= REGS_RST;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    r_nxt.done = 1'b0;
    baud_end  = (r.baud == BAUD_LAST);
    in_crlf   = (r.idx >= MSG_END);
    crlf_byte = (r.idx == MSG_END) ? 8'h0D : 8'h0A;
    idx_plus  = r.idx + IDX_W'(1);

    if (state == S_START || state == S_DATA || state == S_STOP)
      r_nxt.baud = baud_end ? '0 : r.baud + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_REQ;
          r_nxt.idx  = '0;
          r_nxt.busy = 1'b1;
          r_nxt.addr = '0;
          r_nxt.rden = (MSG_END != '0);
        end
      end
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_LATCH;
      S_LATCH: begin
        state_nxt   = S_START;
        r_nxt.shreg = in_crlf ? crlf_byte : ram_q;
        r_nxt.rden  = 1'b0;
        r_nxt.tx    = 1'b0;
      end
      S_START: begin
        if (baud_end) begin
          state_nxt = S_DATA;
          r_nxt.tx  = r.shreg[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (r.bit_cnt == 3'd7) begin
            state_nxt     = S_STOP;
            r_nxt.bit_cnt = '0;
            r_nxt.tx      = 1'b1;
          end else begin
            r_nxt.bit_cnt = r.bit_cnt + 3'd1;
            r_nxt.shreg   = {1'b0, r.shreg[7:1]};
            r_nxt.tx      = r.shreg[1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          r_nxt.idx = idx_plus;
          if (idx_plus < IDX_END) begin
            state_nxt = S_REQ;
            // CR/LF bytes never touch the RAM; address keeps its last value.
            if (idx_plus < MSG_END) begin
              r_nxt.addr = idx_plus[ADDR_W-1:0];
              r_nxt.rden = 1'b1;
            end
          end else begin
            state_nxt  = S_DONE;
            r_nxt.done = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt  = S_IDLE;
        r_nxt.busy = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        r_nxt     = REGS_RST;
      end
    endcase
  end

  assign ram_address = r.addr;
  assign ram_rden    = r.rden;
  assign uart_tx     = r.tx;
  assign busy        = r.busy;
  assign done        = r.done;

endmodule
